// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock with a running carry,
// valid/ready handshakes on both sides, and carry/overflow/zero flags on completion.
module seq_addsub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             V,
  output logic             Z
);

  localparam int unsigned N      = WIDTH / CHUNK;
  localparam int unsigned CNT_W  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned BASE_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
    $error("seq_addsub: WIDTH must be a multiple of CHUNK with 1 <= CHUNK <= WIDTH");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_s;
  logic             r_c;
  logic             r_v;
  logic             r_z;

  logic [BASE_W-1:0] w_base;
  logic [CHUNK-1:0]  w_a_chunk;
  logic [CHUNK-1:0]  w_b_chunk;
  logic [CHUNK:0]    w_sum;
  logic [WIDTH-1:0]  w_s_nxt;
  logic              w_cout;
  logic              w_cmsb;
  logic              w_last;

  // One chunk of the ripple: select chunk k, add with running carry, merge into S
  always_comb begin
    w_base    = BASE_W'(r_cnt) * BASE_W'(CHUNK);
    w_a_chunk = r_a[w_base +: CHUNK];
    w_b_chunk = r_b[w_base +: CHUNK];
    w_sum     = (CHUNK+1)'(w_a_chunk) + (CHUNK+1)'(w_b_chunk) + (CHUNK+1)'(r_carry);
    w_s_nxt   = r_s;
    w_s_nxt[w_base +: CHUNK] = w_sum[CHUNK-1:0];
    w_cout    = w_sum[CHUNK];
    // Carry into the chunk MSB recovered from the sum bit and its two operand bits
    w_cmsb    = w_sum[CHUNK-1] ^ w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1];
    w_last    = (r_cnt == LAST);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= 1'b0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_s     <= '0;
      r_c     <= 1'b0;
      r_v     <= 1'b0;
      r_z     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          // Subtraction is A + ~B + 1: invert B here and seed the carry with Op
          if (in_valid) begin
            r_a     <= A;
            r_b     <= B ^ {WIDTH{Op}};
            r_op    <= Op;
            r_cnt   <= '0;
            r_carry <= Op;
          end
        end
        RUN: begin
          r_s     <= w_s_nxt;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_c <= w_cout ^ r_op;
            r_v <= w_cmsb ^ w_cout;
            r_z <= (w_s_nxt == '0);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Handshake flags decode the registered state; in_ready is masked during reset
  assign in_ready  = rst_n && (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign S         = r_s;
  assign C         = r_c;
  assign V         = r_v;
  assign Z         = r_z;

endmodule

// File: doc/seq_addsub.md
SEQ_ADDSUB -- requirements
Module: seq_addsub

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, meaning the operand and result width in bits.
REQ-002 The module SHALL have parameter CHUNK, default 4, meaning the number of bits added per clock cycle.
REQ-003 The module SHALL accept only configurations where WIDTH is a multiple of CHUNK and CHUNK is at least 1 and at most WIDTH; N = WIDTH/CHUNK throughout this document.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 Port in_valid, input, 1 bit: operands and Op are valid.
REQ-007 Port in_ready, output, 1 bit: the block can accept an operation.
REQ-008 Port A, input, WIDTH bits: augend/minuend.
REQ-009 Port B, input, WIDTH bits: addend/subtrahend.
REQ-010 Port Op, input, 1 bit: 0 = add, 1 = subtract.
REQ-011 Port out_valid, output, 1 bit: result and flags are valid.
REQ-012 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 Port S, output, WIDTH bits: sum/difference.
REQ-014 Port C, output, 1 bit: carry (add) or borrow (subtract).
REQ-015 Port V, output, 1 bit: signed two's-complement overflow.
REQ-016 Port Z, output, 1 bit: S is all zeros.

Function
REQ-017 The state machine SHALL have exactly the states IDLE, RUN and DONE.
REQ-018 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-019 In IDLE, in_valid=1 at a rising edge SHALL capture A, B^{WIDTH{Op}} and Op, clear the chunk counter, set the running carry to Op, and enter RUN.
REQ-020 In RUN, each rising edge SHALL add chunk k of A, chunk k of the conditioned B and the running carry, starting at k=0 (LSB chunk); it SHALL write chunk k of S and update the running carry.
REQ-021 On the edge that processes chunk N-1, the block SHALL register the carry into bit WIDTH-1 and the carry out of bit WIDTH-1 (cout), and SHALL enter DONE.
REQ-022 Latency SHALL be exactly N cycles: out_valid SHALL rise N rising edges after the accepting edge.
REQ-023 In DONE: C = cout XOR Op; V = (carry into MSB) XOR cout; Z = (S == 0).
REQ-024 In DONE, out_valid=1 with out_ready=1 at a rising edge SHALL complete the transfer and return to IDLE.
REQ-025 In DONE, out_ready=0 SHALL hold S, C, V, Z and out_valid stable indefinitely.
REQ-026 There SHALL be no bypass: in_ready rises only the cycle after the output transfer, so back-to-back throughput is one operation per N+2 cycles.
REQ-027 Inputs SHALL be ignored outside IDLE; A, B and Op changing during RUN or DONE SHALL NOT affect the result.
REQ-028 S, C, V and Z SHALL hold their last values in IDLE until the next accept.
REQ-029 When CHUNK = WIDTH, RUN SHALL last exactly one cycle.
REQ-030 All arithmetic SHALL be modulo 2^WIDTH; there SHALL be no saturation.

Reset
REQ-031 rst_n=0 at a rising edge SHALL force IDLE and set S=0, C=0, V=0, Z=0, out_valid=0, chunk counter=0 and running carry=0.
REQ-032 in_ready SHALL be 0 while rst_n=0 and 1 on the first cycle after rst_n returns high.
REQ-033 A reset asserted in RUN or DONE SHALL abandon the operation with no output transfer.
REQ-034 in_valid asserted in the same cycle as rst_n=0 SHALL be ignored.

Verification (WIDTH=16, CHUNK=4 unless noted)
REQ-035 Add 0x7FFF + 0x0001 -> S=0x8000, C=0, V=1, Z=0; out_valid SHALL rise exactly 4 edges after accept.
REQ-036 Sub 0x0005 - 0x0005 -> S=0x0000, C=0, V=0, Z=1; sub 0x0000 - 0x0001 -> S=0xFFFF, C=1, V=0, Z=0.
REQ-037 Add 0xFFFF + 0x0001 -> S=0x0000, C=1, V=0, Z=1; sub 0x8000 - 0x0001 -> S=0x7FFF, C=0, V=1.
REQ-038 Hold out_ready=0 for 5 cycles in DONE while toggling A, B and Op -> outputs stable; then out_ready=1 -> IDLE next edge; a second in_valid is accepted only when in_ready=1.
REQ-039 Assert rst_n=0 on the 2nd RUN cycle -> next edge IDLE with all outputs 0 and no out_valid pulse; a following operation completes correctly.
REQ-040 With CHUNK=16, add 0x1234 + 0x1111 -> S=0x2345, C=0, V=0 with 1-cycle latency; random add/sub for both configs SHALL match a WIDTH+1-bit reference model.
